rv32_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the RV32 core family. Generates sequential PCs, issues

---
 rtl/rv32_fetch_queue_pkg.sv | 13 +
 rtl/rv32_sync_fifo.sv | 79 +++++++
 rtl/rv32_fetch_queue.sv | 108 ++++++++++
 tb/tb_rv32_fetch_queue.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_queue_pkg.sv
// Shared definitions for the RV32 instruction-fetch front end:
// default widths and the fetch FSM state encoding.
package rv32_fetch_queue_pkg;

   localparam int XLEN_DEF = 32;
   localparam int ILEN_DEF = 32;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/rv32_sync_fifo.sv
// Circular-buffer FIFO with flush and simultaneous push/pop at any fill level.
// The head word is kept in a register so it holds its last value once the FIFO empties.
module rv32_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    rd_ptr_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_nxt_s;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    remain_s;
   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] head_nxt_s;
   logic             do_push_s;
   logic             do_pop_s;

   // Handshake qualification and next head word (a word pushed into an emptying FIFO becomes head)
   always_comb begin
      do_pop_s     = pop & (count_r != {CW{1'b0}});
      do_push_s    = push & ((count_r != CW'(DEPTH)) | do_pop_s);
      remain_s     = count_r - CW'(do_pop_s);
      rd_ptr_nxt_s = rd_ptr_r + AW'(do_pop_s);
      head_nxt_s   = head_r;
      if (flush) begin
         head_nxt_s = head_r;
      end else if (remain_s != {CW{1'b0}}) begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end else if (do_push_s) begin
         head_nxt_s = wr_data;
      end else begin
         head_nxt_s = head_r;
      end
   end

   // Pointer, occupancy and head register update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         head_r   <= {WIDTH{1'b0}};
      end else if (flush) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= wr_ptr_r + AW'(do_push_s);
         count_r  <= remain_s + CW'(do_push_s);
         head_r   <= head_nxt_s;
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   assign rd_data = head_r;
   assign valid   = (count_r != {CW{1'b0}});
   assign count   = count_r;

endmodule

// File: rtl/rv32_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding memory
// requests with credit flow control, response queueing and redirect/flush handling.
module rv32_fetch_queue
   import rv32_fetch_queue_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter int              ILEN     = ILEN_DEF,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            ENABLE,
   output logic            IMEM_REQ,
   output logic [XLEN-1:0] IMEM_ADDR,
   input  logic            IMEM_GNT,
   input  logic            IMEM_RVALID,
   input  logic [ILEN-1:0] IMEM_RDATA,
   input  logic            REDIRECT,
   input  logic [XLEN-1:0] REDIRECT_PC,
   output logic            INSTR_VALID,
   input  logic            INSTR_READY,
   output logic [ILEN-1:0] INSTR,
   output logic [XLEN-1:0] INSTR_PC
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e            state_r;
   fetch_state_e            state_nxt_s;
   logic [XLEN-1:0]         pc_r;
   logic [XLEN-1:0]         pc_nxt_s;
   logic [XLEN-1:0]         tag_r;
   logic                    inflight_r;
   logic                    drop_r;
   logic                    room_s;
   logic                    accept_s;
   logic                    push_s;
   logic [CW-1:0]           fifo_count_s;
   logic [ILEN+XLEN-1:0]    head_s;
   logic                    unused_pc_bits_s;

   // A queue slot must exist for every outstanding request, including the one in flight
   assign room_s   = (fifo_count_s + CW'(inflight_r)) < CW'(DEPTH);
   assign IMEM_REQ = (state_r == ST_FETCH) & room_s & ~REDIRECT;
   assign accept_s = IMEM_REQ & IMEM_GNT;
   assign push_s   = IMEM_RVALID & inflight_r & ~drop_r & ~REDIRECT;
   assign IMEM_ADDR = pc_r;
   assign unused_pc_bits_s = ^REDIRECT_PC[1:0];

   // Next-state and next-PC selection; redirect overrides everything
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      if (REDIRECT) begin
         state_nxt_s = ENABLE ? ST_FETCH : ST_IDLE;
         pc_nxt_s    = {REDIRECT_PC[XLEN-1:2], 2'b00};
      end else begin
         case (state_r)
            ST_IDLE:  state_nxt_s = ENABLE ? ST_FETCH : ST_IDLE;
            ST_FETCH: state_nxt_s = ENABLE ? ST_FETCH : ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
         endcase
         if (accept_s) begin
            pc_nxt_s = pc_r + XLEN'(3'd4);
         end else begin
            pc_nxt_s = pc_r;
         end
      end
   end

   // FSM, PC and outstanding-request bookkeeping
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r    <= ST_IDLE;
         pc_r       <= RESET_PC;
         tag_r      <= {XLEN{1'b0}};
         inflight_r <= 1'b0;
         drop_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         pc_r       <= pc_nxt_s;
         inflight_r <= accept_s;
         drop_r     <= REDIRECT & inflight_r;
         if (accept_s) begin
            tag_r <= pc_r;
         end
      end
   end

   rv32_sync_fifo #(
      .WIDTH (ILEN + XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (CLK),
      .rst     (RST),
      .flush   (REDIRECT),
      .push    (push_s),
      .wr_data ({IMEM_RDATA, tag_r}),
      .pop     (INSTR_READY),
      .rd_data (head_s),
      .valid   (INSTR_VALID),
      .count   (fifo_count_s)
   );

   assign INSTR    = head_s[ILEN+XLEN-1:XLEN];
   assign INSTR_PC = head_s[XLEN-1:0];

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Self-checking bench for rv32_fetch_queue: directed scenarios plus randomized traffic,
// checked against a queue-based model of the decode-visible instruction stream.
module tb_rv32_fetch_queue;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ENABLE;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT;
   logic        IMEM_RVALID;
   logic [31:0] IMEM_RDATA;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic [31:0] INSTR;
   logic [31:0] INSTR_PC;

   int errors = 0;
   int checks = 0;

   // Model: every accepted request becomes visible to decode 2 cycles later, in order
   logic [31:0] q_pc[$];
   int          q_rdy[$];
   logic [31:0] pc_m;
   bit          en_m;
   int          cyc;
   bit          last_acc;

   rv32_fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
      .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
      .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .INSTR_VALID(INSTR_VALID),
      .INSTR_READY(INSTR_READY), .INSTR(INSTR), .INSTR_PC(INSTR_PC));

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // Synchronous memory: answers every accepted request one cycle later
   always @(posedge CLK) begin
      IMEM_RVALID <= IMEM_REQ & IMEM_GNT;
      IMEM_RDATA  <= mem_f(IMEM_ADDR);
   end

   function automatic bit exp_req_f();
      return en_m && (q_pc.size() < DEPTH) && !REDIRECT;
   endfunction

   function automatic bit exp_valid_f();
      return (q_pc.size() > 0) && (q_rdy[0] <= cyc);
   endfunction

   task automatic model_reset();
      q_pc.delete();
      q_rdy.delete();
      pc_m = 32'h0000_0000;
      en_m = 1'b0;
   endtask

   task automatic drive(input bit en, input bit gnt, input bit rdy, input bit rd, input logic [31:0] rpc);
      ENABLE = en; IMEM_GNT = gnt; INSTR_READY = rdy; REDIRECT = rd; REDIRECT_PC = rpc;
   endtask

   // Called at the negative edge: advance one clock and update the model
   task automatic tick();
      bit acc, pp, rd;
      acc = exp_req_f() && IMEM_GNT;
      pp  = exp_valid_f() && INSTR_READY;
      rd  = REDIRECT;
      @(posedge CLK);
      #1;
      if (rd) begin
         q_pc.delete();
         q_rdy.delete();
         pc_m = {REDIRECT_PC[31:2], 2'b00};
      end else begin
         if (pp) begin
            void'(q_pc.pop_front());
            void'(q_rdy.pop_front());
         end
         if (acc) begin
            q_pc.push_back(pc_m);
            q_rdy.push_back(cyc + 2);
            pc_m = pc_m + 32'd4;
         end
      end
      last_acc = acc;
      en_m = ENABLE;
      cyc++;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", IMEM_REQ); end
      checks++; if (IMEM_ADDR !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", IMEM_ADDR); end
      checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", INSTR_VALID); end
      checks++; if (INSTR !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", INSTR); end
      checks++; if (INSTR_PC !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got=%h exp=0", INSTR_PC); end
      RST = 1'b0;
      model_reset();
      cyc = 0;
      @(posedge CLK);
      #1;
      @(negedge CLK);
      checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", IMEM_REQ); end
      tick();
   endtask

   task automatic test_stream();
      int first_acc = -1, first_val = -1, pops = 0;
      logic [31:0] exp_next = 32'h0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         @(negedge CLK);
         checks++; if (IMEM_REQ !== exp_req_f()) begin errors++; $display("FAIL stream_req i=%0d got=%b exp=%b", i, IMEM_REQ, exp_req_f()); end
         checks++; if (INSTR_VALID !== exp_valid_f()) begin errors++; $display("FAIL stream_valid i=%0d got=%b exp=%b", i, INSTR_VALID, exp_valid_f()); end
         if (INSTR_VALID === 1'b1) begin
            checks++;
            if ({INSTR_PC, INSTR} !== {exp_next, mem_f(exp_next)}) begin
               errors++; $display("FAIL stream_order i=%0d got=%h/%h exp=%h/%h", i, INSTR_PC, INSTR, exp_next, mem_f(exp_next));
            end
            exp_next = exp_next + 32'd4;
            pops++;
         end
         if (IMEM_REQ === 1'b1 && first_acc < 0) first_acc = i;
         if (INSTR_VALID === 1'b1 && first_val < 0) first_val = i;
         tick();
      end
      checks++; if (first_acc != 1) begin errors++; $display("FAIL stream_first_req got=%0d exp=1", first_acc); end
      checks++; if (first_val - first_acc != 2) begin errors++; $display("FAIL stream_latency got=%0d exp=2", first_val - first_acc); end
      checks++; if (pops != 17) begin errors++; $display("FAIL stream_throughput got=%0d exp=17", pops); end
   endtask

   task automatic test_backpressure();
      int accs = 0, accs2 = 0;
      logic [31:0] exp_next;
      for (int i = 0; i < 6; i++) begin drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); @(negedge CLK); tick(); end
      exp_next = pc_m;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         @(negedge CLK);
         checks++; if (IMEM_REQ !== exp_req_f()) begin errors++; $display("FAIL bp_req i=%0d got=%b exp=%b", i, IMEM_REQ, exp_req_f()); end
         if (IMEM_REQ === 1'b1) accs++;
         tick();
      end
      checks++; if (accs != DEPTH) begin errors++; $display("FAIL bp_accepts got=%0d exp=%0d", accs, DEPTH); end
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         @(negedge CLK);
         checks++; if (INSTR_VALID !== exp_valid_f()) begin errors++; $display("FAIL bp_valid i=%0d got=%b exp=%b", i, INSTR_VALID, exp_valid_f()); end
         if (INSTR_VALID === 1'b1) begin
            checks++;
            if ({INSTR_PC, INSTR} !== {exp_next, mem_f(exp_next)}) begin
               errors++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, INSTR_PC, exp_next);
            end
            exp_next = exp_next + 32'd4;
         end
         if (IMEM_REQ === 1'b1) accs2++;
         tick();
      end
      checks++; if (accs2 < 8) begin errors++; $display("FAIL bp_resume got=%0d exp>=8", accs2); end
   endtask

   task automatic test_redirect();
      bit found = 1'b0, seen = 1'b0;
      for (int i = 0; i < 4; i++) begin drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); @(negedge CLK); tick(); end
      for (int i = 0; i < 10 && !found; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         @(negedge CLK);
         tick();
         if (q_pc.size() == 3 && last_acc) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL redir_setup got=notfound exp=found"); end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
      @(negedge CLK);
      checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL redir_req got=%b exp=0", IMEM_REQ); end
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge CLK);
      checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL redir_flush got=%b exp=0", INSTR_VALID); end
      checks++; if (IMEM_ADDR !== 32'h0000_0100) begin errors++; $display("FAIL redir_addr got=%h exp=00000100", IMEM_ADDR); end
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         @(negedge CLK);
         if (INSTR_VALID === 1'b1 && !seen) begin
            seen = 1'b1;
            checks++;
            if ({INSTR_PC, INSTR} !== {32'h0000_0100, mem_f(32'h0000_0100)}) begin
               errors++; $display("FAIL redir_first got=%h/%h exp=00000100/%h", INSTR_PC, INSTR, mem_f(32'h100));
            end
         end
         tick();
      end
      checks++; if (!seen) begin errors++; $display("FAIL redir_resume got=novalid exp=valid"); end
   endtask

   task automatic test_back_to_back();
      int pops = 0;
      logic [31:0] exp_next = 32'h0000_0300;
      for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0); @(negedge CLK); tick(); end
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      @(negedge CLK);
      checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL b2b_req1 got=%b exp=0", IMEM_REQ); end
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
      @(negedge CLK);
      checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL b2b_req2 got=%b exp=0", IMEM_REQ); end
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
         @(negedge CLK);
         if (INSTR_VALID === 1'b1) begin
            checks++;
            if (INSTR_PC !== exp_next) begin errors++; $display("FAIL b2b_order got=%h exp=%h", INSTR_PC, exp_next); end
            exp_next = exp_next + 32'd4;
            pops++;
         end
         tick();
      end
      checks++; if (pops != 8) begin errors++; $display("FAIL b2b_pops got=%0d exp=8", pops); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_next = 32'hFFFF_FFFC;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
      @(negedge CLK);
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge CLK);
      checks++; if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_top got=%b/%h exp=1/fffffffc", IMEM_REQ, IMEM_ADDR); end
      tick();
      @(negedge CLK);
      checks++; if (IMEM_ADDR !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got=%h exp=00000000", IMEM_ADDR); end
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         if (INSTR_VALID === 1'b1) begin
            checks++;
            if ({INSTR_PC, INSTR} !== {exp_next, mem_f(exp_next)}) begin errors++; $display("FAIL wrap_order got=%h exp=%h", INSTR_PC, exp_next); end
            exp_next = exp_next + 32'd4;
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0); @(negedge CLK); tick(); end
      @(negedge CLK);
      checks++; if ({IMEM_REQ, INSTR_VALID} !== 2'b01) begin errors++; $display("FAIL full_state got=%b%b exp=01", IMEM_REQ, INSTR_VALID); end
      #2;
      RST = 1'b1;
      #1;
      checks++;
      if ({IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR, INSTR_PC} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
         errors++; $display("FAIL async_reset got=%b/%h/%b/%h/%h exp=0/0/0/0/0", IMEM_REQ, IMEM_ADDR, INSTR_VALID, INSTR, INSTR_PC);
      end
      model_reset();
      @(posedge CLK);
      #3;
      RST = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge CLK);
      checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL post_reset_req got=%b exp=0", IMEM_REQ); end
      tick();
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         checks++; if (INSTR_VALID !== exp_valid_f()) begin errors++; $display("FAIL post_reset_valid i=%0d got=%b exp=%b", i, INSTR_VALID, exp_valid_f()); end
         if (INSTR_VALID === 1'b1 && !seen) begin
            seen = 1'b1;
            checks++; if (INSTR_PC !== 32'h0) begin errors++; $display("FAIL post_reset_pc got=%h exp=00000000", INSTR_PC); end
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
               $urandom_range(0, 19) == 0, $urandom);
         @(negedge CLK);
         checks++; if (IMEM_REQ !== exp_req_f()) begin errors++; $display("FAIL rand_req i=%0d got=%b exp=%b", i, IMEM_REQ, exp_req_f()); end
         checks++; if (IMEM_ADDR !== pc_m) begin errors++; $display("FAIL rand_addr i=%0d got=%h exp=%h", i, IMEM_ADDR, pc_m); end
         checks++; if (INSTR_VALID !== exp_valid_f()) begin errors++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, INSTR_VALID, exp_valid_f()); end
         if (exp_valid_f()) begin
            checks++;
            if ({INSTR_PC, INSTR} !== {q_pc[0], mem_f(q_pc[0])}) begin
               errors++; $display("FAIL rand_head i=%0d got=%h/%h exp=%h/%h", i, INSTR_PC, INSTR, q_pc[0], mem_f(q_pc[0]));
            end
         end
         tick();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
